step_iface: RTL and testbench

STEP_IFACE -- requirements
Module: step_iface

---
 rtl/step_iface_pkg.sv | 64 ++++++
 rtl/step_iface_if.sv | 27 ++
 rtl/step_iface_hex7.sv | 14 +
 rtl/step_iface.sv | 172 +++++++++++++++++
 tb/tb_step_iface.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_iface_pkg.sv
// Shared types, seven-segment glyphs and sizing helpers for the step_iface
// key/switch loader and its hex display decoders.
package step_iface_pkg;

    typedef enum logic {
        KEY_PRESSED  = 1'b0,
        KEY_RELEASED = 1'b1
    } key_lvl_e;

    // Active-low glyphs; bit 0 = top segment, 1..5 clockwise, 6 = middle.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Width of the byte-select switch field for a given datapath width.
    function automatic int bsel_w(input int data_w);
        int nbytes;
        nbytes = data_w / 8;
        if (nbytes <= 1) begin
            return 1;
        end else begin
            return $clog2(nbytes);
        end
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/step_iface_if.sv
// Switch/load bus between the board switches and the step_iface loader:
// master drives the switch fields, slave returns step and latched words.
interface step_iface_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 9
);
    localparam int BSEL_W = step_iface_pkg::bsel_w(DATA_W);

    logic              sw_mode;
    logic [BSEL_W-1:0] sw_byte;
    logic [8:0]        sw_val;
    logic              step;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [8:0]        led;

    modport master (
        output sw_mode, sw_byte, sw_val,
        input  step, data_out, ctrl_out, led
    );

    modport slave (
        input  sw_mode, sw_byte, sw_val,
        output step, data_out, ctrl_out, led
    );

endinterface

// File: rtl/step_iface_hex7.sv
// Single hexadecimal digit to active-low seven-segment decoder.
module hex7
    import step_iface_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Glyph lookup from the shared segment table.
    always_comb begin
        seg = seg_of(nib);
    end

endmodule

// File: rtl/step_iface.sv
// Debounced push-button stepper that loads switch values into data/control
// registers and drives hex displays. Define STEP_AUTOREPEAT_EN for auto-repeat.
module step_iface
    import step_iface_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int CTRL_W       = 9,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_CYC   = 12500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_n,
    step_iface_if.slave           bus,
    input  logic [DATA_W-1:0]     disp_in,
    output logic [7*DATA_W/4-1:0] hex
);

    localparam int NBYTES  = DATA_W / 8;
    localparam int NDIGITS = DATA_W / 4;
    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic              sync1_q;
    logic              sync1_d;
    logic              sync2_q;
    logic              sync2_d;
    key_lvl_e          level_q;
    key_lvl_e          level_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic              step_q;
    logic              step_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic              press_s;
    logic              rpt_fire_s;
    logic              fire_s;
    logic [7:0]        byte_idx_s;
    logic [7:0]        sel_byte_s;
    logic [8:0]        led_s;

    // Synchronizer and debounce counter next-state.
    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = {DB_W{1'b0}};
        if (key_lvl_e'(sync2_q) != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                level_d  = key_lvl_e'(sync2_q);
                db_cnt_d = {DB_W{1'b0}};
            end else begin
                level_d  = level_q;
                db_cnt_d = db_cnt_q + DB_W'(1'b1);
            end
        end else begin
            level_d  = level_q;
            db_cnt_d = {DB_W{1'b0}};
        end
    end

    assign press_s = (level_q == KEY_RELEASED) && (level_d == KEY_PRESSED);

`ifdef STEP_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;

    // Repeat timer runs only while the accepted level stays pressed.
    always_comb begin
        rpt_cnt_d  = {RPT_W{1'b0}};
        rpt_fire_s = 1'b0;
        if ((level_q == KEY_PRESSED) && (level_d == KEY_PRESSED)) begin
            if (rpt_cnt_q == RPT_W'(REPEAT_CYC - 1)) begin
                rpt_cnt_d  = {RPT_W{1'b0}};
                rpt_fire_s = 1'b1;
            end else begin
                rpt_cnt_d  = rpt_cnt_q + RPT_W'(1'b1);
                rpt_fire_s = 1'b0;
            end
        end else begin
            rpt_cnt_d  = {RPT_W{1'b0}};
            rpt_fire_s = 1'b0;
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= {RPT_W{1'b0}};
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;

    // Keeps the repeat period referenced when auto-repeat is compiled out.
    if (REPEAT_CYC < 1) begin : g_repeat_unused
    end
`endif

    assign fire_s     = press_s | rpt_fire_s;
    assign byte_idx_s = 8'(bus.sw_byte);

    // Switch fields are consumed only on the cycle a step is issued.
    always_comb begin
        step_d = fire_s;
        data_d = data_q;
        ctrl_d = ctrl_q;
        for (int b = 0; b < NBYTES; b++) begin
            data_d[8*b +: 8] = (fire_s && bus.sw_mode && (byte_idx_s == 8'(b)))
                             ? bus.sw_val[7:0] : data_q[8*b +: 8];
        end
        if (fire_s && !bus.sw_mode) begin
            ctrl_d = bus.sw_val[CTRL_W-1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Status display mirrors the register the switches currently target.
    always_comb begin
        sel_byte_s = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            sel_byte_s = sel_byte_s
                       | ((byte_idx_s == 8'(b)) ? data_q[8*b +: 8] : 8'h00);
        end
        if (bus.sw_mode) begin
            led_s = {1'b0, sel_byte_s};
        end else begin
            led_s = 9'(ctrl_q);
        end
    end

    // Key path and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            level_q  <= KEY_RELEASED;
            db_cnt_q <= {DB_W{1'b0}};
            step_q   <= 1'b0;
            data_q   <= {DATA_W{1'b0}};
            ctrl_q   <= {CTRL_W{1'b0}};
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            step_q   <= step_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign bus.step     = step_q;
    assign bus.data_out = data_q;
    assign bus.ctrl_out = ctrl_q;
    assign bus.led      = led_s;

    for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
        hex7 u_hex7 (
            .nib (disp_in[4*k +: 4]),
            .seg (hex[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_step_iface.sv
// Scoreboard bench for step_iface: a 16-bit and an 8-bit instance share the
// key and switch stimulus; expected register contents are queued per step.
`timescale 1ns/1ps
module tb_step_iface;

    localparam int DB = 4;
    localparam int RP = 10;

    typedef struct {
        logic [15:0] d16;
        logic [7:0]  d8;
        logic [8:0]  ctrl;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_n = 1'b1;
    logic [15:0] disp16 = 16'h0000;
    logic [7:0]  disp8  = 8'h00;
    logic [27:0] hex16;
    logic [13:0] hex8;

    int   total   = 0;
    int   bad     = 0;
    int   steps16 = 0;
    int   steps8  = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [15:0] m_d16  = 16'h0000;
    logic [7:0]  m_d8   = 8'h00;
    logic [8:0]  m_ctrl = 9'h000;
    logic        cur_mode = 1'b0;
    int          cur_byte = 0;
    logic [8:0]  cur_val  = 9'h000;

    step_iface_if #(.DATA_W(16), .CTRL_W(9)) bus16 ();
    step_iface_if #(.DATA_W(8),  .CTRL_W(9)) bus8 ();

    step_iface #(.DATA_W(16), .CTRL_W(9), .DEBOUNCE_CYC(DB), .REPEAT_CYC(RP)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .bus(bus16), .disp_in(disp16), .hex(hex16)
    );

    step_iface #(.DATA_W(8), .CTRL_W(9), .DEBOUNCE_CYC(DB), .REPEAT_CYC(RP)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .bus(bus8), .disp_in(disp8), .hex(hex8)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] exp_seg(input int v);
        case (v)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // Scoreboard: every step pops the register contents it must have produced.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus16.step === 1'b1 || bus8.step === 1'b1)) begin
            if (bus16.step === 1'b1) steps16++;
            if (bus8.step === 1'b1) steps8++;
            total++;
            if (bus16.step !== bus8.step) begin
                bad++;
                $display("FAIL step_align: step16=%b step8=%b required equal", bus16.step, bus8.step);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_step: at %0t no step expected", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus16.data_out !== mon_e.d16 || bus8.data_out !== mon_e.d8 ||
                    bus16.ctrl_out !== mon_e.ctrl || bus8.ctrl_out !== mon_e.ctrl) begin
                    bad++;
                    $display("FAIL step_load: d16=%h d8=%h c16=%h c8=%h required d16=%h d8=%h ctrl=%h",
                             bus16.data_out, bus8.data_out, bus16.ctrl_out, bus8.ctrl_out,
                             mon_e.d16, mon_e.d8, mon_e.ctrl);
                end
            end
        end
    end

    task automatic set_sw(input logic mode, input int byt, input logic [8:0] val);
        cur_mode = mode;
        cur_byte = byt;
        cur_val  = val;
        bus16.sw_mode = mode;
        bus16.sw_byte = byt[0];
        bus16.sw_val  = val;
        bus8.sw_mode  = mode;
        bus8.sw_byte  = byt[0];
        bus8.sw_val   = val;
    endtask

    task automatic push_expect();
        exp_t e;
        if (cur_mode) begin
            if (cur_byte < 2) m_d16[8*cur_byte +: 8] = cur_val[7:0];
            if (cur_byte < 1) m_d8 = cur_val[7:0];
        end else begin
            m_ctrl = cur_val;
        end
        e.d16  = m_d16;
        e.d8   = m_d8;
        e.ctrl = m_ctrl;
        exp_q.push_back(e);
    endtask

    task automatic press(input int hold);
        key_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        set_sw(1'b0, 0, 9'h000);
        repeat (3) @(negedge clk);
        total++;
        if (bus16.step !== 1'b0 || bus8.step !== 1'b0) begin
            bad++; $display("FAIL reset_step: got %b/%b required 0", bus16.step, bus8.step);
        end
        total++;
        if (bus16.data_out !== 16'h0000 || bus8.data_out !== 8'h00) begin
            bad++; $display("FAIL reset_data: got %h/%h required 0", bus16.data_out, bus8.data_out);
        end
        total++;
        if (bus16.ctrl_out !== 9'h000 || bus16.led !== 9'h000) begin
            bad++; $display("FAIL reset_ctrl_led: got %h/%h required 0", bus16.ctrl_out, bus16.led);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (steps16 !== 0) begin
            bad++; $display("FAIL reset_no_step: got %0d steps required 0", steps16);
        end
    endtask

    task automatic test_load_byte();
        int s16, s8;
        s16 = steps16;
        s8  = steps8;
        set_sw(1'b1, 1, 9'h0A5);
        push_expect();
        press(8);
        total++;
        if (steps16 !== s16 + 1 || steps8 !== s8 + 1) begin
            bad++; $display("FAIL load_step_count: got %0d/%0d required %0d/%0d", steps16 - s16, steps8 - s8, 1, 1);
        end
        total++;
        if (bus16.data_out !== 16'hA500) begin
            bad++; $display("FAIL load_data16: got %h required a500", bus16.data_out);
        end
        total++;
        if (bus8.data_out !== 8'h00) begin
            bad++; $display("FAIL load_data8_out_of_range: got %h required 00", bus8.data_out);
        end
        total++;
        if (bus16.led !== 9'h0A5 || bus8.led !== 9'h000) begin
            bad++; $display("FAIL load_led: got %h/%h required 0a5/000", bus16.led, bus8.led);
        end
    endtask

    task automatic test_bounce();
        int s16;
        s16 = steps16;
        set_sw(1'b1, 0, 9'h03C);
        for (int k = 0; k < 20; k++) begin
            key_n = (k % 3 == 2);
            @(negedge clk);
        end
        total++;
        if (steps16 !== s16) begin
            bad++; $display("FAIL bounce_glitch_step: got %0d steps required 0", steps16 - s16);
        end
        push_expect();
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (steps16 !== s16 + 1) begin
            bad++; $display("FAIL bounce_step_count: got %0d required 1", steps16 - s16);
        end
        total++;
        if (bus16.data_out !== 16'hA53C || bus8.data_out !== 8'h3C) begin
            bad++; $display("FAIL bounce_data: got %h/%h required a53c/3c", bus16.data_out, bus8.data_out);
        end
    endtask

    task automatic test_ctrl_hold();
        int s16;
        set_sw(1'b0, 0, 9'h1FF);
        push_expect();
        press(8);
        total++;
        if (bus16.ctrl_out !== 9'h1FF || bus8.ctrl_out !== 9'h1FF) begin
            bad++; $display("FAIL ctrl_load: got %h/%h required 1ff", bus16.ctrl_out, bus8.ctrl_out);
        end
        total++;
        if (bus16.led !== 9'h1FF) begin
            bad++; $display("FAIL ctrl_led: got %h required 1ff", bus16.led);
        end
        s16 = steps16;
        for (int k = 0; k < 8; k++) begin
            set_sw(logic'(k & 1), (k >> 1) & 1, 9'($urandom_range(0, 511)));
            @(negedge clk);
        end
        set_sw(1'b1, 0, 9'h000);
        @(negedge clk);
        total++;
        if (bus16.ctrl_out !== 9'h1FF || bus16.data_out !== 16'hA53C || steps16 !== s16) begin
            bad++; $display("FAIL switch_idle_hold: ctrl=%h data=%h steps=%0d required 1ff/a53c/0",
                            bus16.ctrl_out, bus16.data_out, steps16 - s16);
        end
        total++;
        if (bus16.led !== 9'h03C) begin
            bad++; $display("FAIL data_led_byte0: got %h required 03c", bus16.led);
        end
    endtask

    task automatic test_hex();
        disp16 = 16'h1234;
        disp8  = 8'h34;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hex16[7*k +: 7] !== exp_seg(4 - k)) begin
                bad++; $display("FAIL hex_digit%0d: got %h required %h", k, hex16[7*k +: 7], exp_seg(4 - k));
            end
        end
        total++;
        if (hex8 !== {exp_seg(3), exp_seg(4)}) begin
            bad++; $display("FAIL hex8_digits: got %h required %h", hex8, {exp_seg(3), exp_seg(4)});
        end
        for (int v = 0; v < 16; v++) begin
            disp16 = {4{4'(v)}};
            #1;
            total++;
            if (hex16[6:0] !== exp_seg(v) || hex16[27:21] !== exp_seg(v)) begin
                bad++; $display("FAIL hex_glyph_%0d: got %h/%h required %h", v, hex16[6:0], hex16[27:21], exp_seg(v));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   s16, lat;
        bit   found;
        set_sw(1'b1, 0, 9'h055);
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_d16  = 16'h0000;
        m_d8   = 8'h00;
        m_ctrl = 9'h000;
        exp_q.delete();
        total++;
        if (bus16.data_out !== 16'h0000 || bus16.ctrl_out !== 9'h000 || bus16.step !== 1'b0 ||
            bus8.data_out !== 8'h00 || bus16.led !== 9'h000) begin
            bad++; $display("FAIL async_reset: data=%h ctrl=%h step=%b data8=%h led=%h required all 0",
                            bus16.data_out, bus16.ctrl_out, bus16.step, bus8.data_out, bus16.led);
        end
        s16 = steps16;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_expect();
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (bus16.step === 1'b1) begin
                found = 1'b1;
                lat   = k;
            end
        end
        key_n = 1'b1;
        total++;
        if (!found || lat < DB + 2 || lat > DB + 4) begin
            bad++; $display("FAIL held_key_latency: got %0d (found=%b) required %0d..%0d", lat, found, DB + 2, DB + 4);
        end
        repeat (12) @(negedge clk);
        total++;
        if (steps16 !== s16 + 1 || bus16.data_out !== 16'h0055) begin
            bad++; $display("FAIL post_reset_load: steps=%0d data=%h required 1/0055", steps16 - s16, bus16.data_out);
        end
    endtask

`ifdef STEP_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int n, t_last, gaps_bad;
        bit found;
        set_sw(1'b1, 1, 9'h0C3);
        for (int i = 0; i < 4; i++) push_expect();
        key_n = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus16.step === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL repeat_first_step: no step within 20 cycles");
        end
        n = 1;
        t_last = 0;
        gaps_bad = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 33) key_n = 1'b1;
            if (bus16.step === 1'b1) begin
                n++;
                if (c - t_last != RP) gaps_bad++;
                t_last = c;
            end
        end
        total++;
        if (n !== 4) begin
            bad++; $display("FAIL repeat_count: got %0d pulses required 4", n);
        end
        total++;
        if (gaps_bad !== 0) begin
            bad++; $display("FAIL repeat_spacing: got %0d wrong gaps required 0", gaps_bad);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_byte();
        test_bounce();
        test_ctrl_hold();
        test_hex();
        test_reset_mid();
`ifdef STEP_AUTOREPEAT_EN
        test_autorepeat();
`endif
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
